tawas_regfile: RTL and testbench
================================

# tawas_regfile

Per-thread register-context file for the Tawas barrel core, directly downstream of instruction fetch. It holds 8 x 32-bit registers for each of 32 hardware threads. It loads a thread's context when fetch signals the load stage, carries that context down a 4-deep pipeline while immediate, AU and LS results are merged in, and writes it back to storage at the store stage. Decode and execute units read the full context of the thread in decode from a single registered bus.

## Interface
- THREADS, 32, hardware thread count; thread id width is 5 bits.
- REGS, 8, registers per thread; register index width is 3 bits.
- DW, 32, register width.
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- thread_load_en  input  1  a thread is in the load stage (S3) this cycle
- thread_load  input  5  thread id in S3
- thread_decode  input  5  thread id in S4; used as a consistency check only
- thread_store  input  5  thread id in S7; used as a consistency check only
- rf_imm_en  input  1  S4 immediate write
- rf_imm_reg  input  3  S4 immediate destination register
- rf_imm  input  32  S4 immediate data
- au_wr_en  input  1  S5 AU result write
- au_wr_reg  input  3  S5 AU destination register
- au_wr_data  input  32  S5 AU result data
- ls_wr_en  input  1  S6 load result write
- ls_wr_reg  input  3  S6 load destination register
- ls_wr_data  input  32  S6 load result data
- rf_rdata  output  256  S4 context; r0 is bits [31:0], r7 is bits [255:224]
- rf_rdata_vld  output  1  rf_rdata is valid
- rf_err  output  1  sticky thread-id mismatch flag

## Operation
- Storage is 32 entries x 256 bits, with one synchronous read port and one synchronous write port. Storage is not reset; a thread's contents are undefined until software writes every register.
- Pipeline registers: ctx4, ctx5, ctx6, ctx7. Each holds a valid bit, a 5-bit thread id and a 256-bit context.
- Load (end of S3): if thread_load_en, ctx4 <= {1, thread_load, mem[thread_load]}. Otherwise ctx4.valid <= 0.
- S4 -> S5: ctx5 <= ctx4. If ctx4.valid && rf_imm_en, register rf_imm_reg is replaced with rf_imm.
- S5 -> S6: ctx6 <= ctx5. If ctx5.valid && au_wr_en, register au_wr_reg is replaced with au_wr_data.
- S6 -> S7: ctx7 <= ctx6. If ctx6.valid && ls_wr_en, register ls_wr_reg is replaced with ls_wr_data.
- Store (end of S7): if ctx7.valid, mem[ctx7.id] <= ctx7.ctx.
- Write enables arriving while the matching stage is invalid are ignored.
- rf_rdata = ctx4.ctx and rf_rdata_vld = ctx4.valid. rf_rdata is the pre-immediate value.
- rf_err is set, and stays set until reset, in either case:
  - ctx4.valid && thread_decode != ctx4.id
  - ctx7.valid && thread_store != ctx7.id

## Timing
- Load-to-read latency is 1 cycle: the thread_load_en edge is followed by rf_rdata in the next cycle.
- An immediate written in S4 is not visible on rf_rdata for the same pass. It is visible on the thread's next pass.
- Each of the load, S5, S6 and S7 positions can hold a different thread; all four advance every cycle with no stalls.
- Store/load collision (same cycle, same entry): the read returns the newly written context (write-first). Fetch guarantees a gap of at least 2 cycles between a thread's store and its next load, but the write-first bypass is still mandatory.
- Reset: all ctx valid bits clear, rf_rdata_vld = 0, rf_rdata = 0, rf_err = 0.
- Reset mid-operation: in-flight contexts are dropped and never stored. Storage keeps its prior contents.

## Structure
- Package tawas_pkg:
  - constants TAWAS_THREADS=32, TAWAS_REGS=8
  - typedef tawas_ctx_t as a packed array of 8 x 32 bits
  - typedef tawas_tid_t as 5 bits
- Sub-module tawas_rf_mem: 32 x 256 storage with write-first read and no reset.
- Register merge logic is shared by a function: ctx_write(ctx, en, reg, data).

## Test plan
- Write r3 of thread 5 via rf_imm = 0x0000_1234, then reload thread 5 -> rf_rdata[127:96] = 0x0000_1234 one cycle after thread_load_en; rf_rdata_vld = 1.
- Back-to-back threads 0, 1, 2 with AU writes r1 = 0xA, 0xB, 0xC respectively in each thread's S5 -> each thread's reload shows its own r1; no cross-thread corruption.
- Same-pass writes to r2 of thread 9: imm = 1 in S4, au = 2 in S5, ls = 3 in S6 -> reload shows r2 = 3 (the latest stage wins).
- Store of thread 7 and load of thread 7 in the same cycle -> rf_rdata equals the just-stored context.
- thread_decode = 4 while ctx4.id = 6 -> rf_err rises the next cycle and stays high until rst.
- Assert rst with 4 valid contexts in flight -> rf_rdata_vld = 0 the next cycle; pre-reset storage contents are unchanged on reload.

Source files
------------

// File: rtl/tawas_pkg.sv
// Shared types and the register-merge helper for the Tawas per-thread register file.
package tawas_pkg;

  localparam int TAWAS_THREADS = 32;
  localparam int TAWAS_REGS    = 8;
  localparam int TAWAS_DW      = 32;
  localparam int TAWAS_TID_W   = 5;
  localparam int TAWAS_REG_W   = 3;

  typedef logic [TAWAS_REGS-1:0][TAWAS_DW-1:0] tawas_ctx_t;
  typedef logic [TAWAS_TID_W-1:0]              tawas_tid_t;
  typedef logic [TAWAS_REG_W-1:0]              tawas_reg_t;

  typedef struct packed {
    logic       valid;
    tawas_tid_t id;
    tawas_ctx_t ctx;
  } tawas_stage_t;

  // Replace one register of a context when en is set; every pipeline merge point uses this.
  function automatic tawas_ctx_t ctx_write(input tawas_ctx_t          ctx,
                                           input logic                en,
                                           input tawas_reg_t          wreg,
                                           input logic [TAWAS_DW-1:0] data);
    tawas_ctx_t res;
    res = ctx;
    if (en) res[wreg] = data;
    return res;
  endfunction

endpackage

// File: rtl/tawas_rf_mem.sv
// 32 x 256-bit context storage: one synchronous read port, one write port, write-first.
module tawas_rf_mem
  import tawas_pkg::*;
(
  input  logic       clk,
  input  logic       rd_en_i,
  input  tawas_tid_t rd_addr_i,
  output tawas_ctx_t rd_data_o,
  input  logic       wr_en_i,
  input  tawas_tid_t wr_addr_i,
  input  tawas_ctx_t wr_data_i
);

  tawas_ctx_t mem_q [TAWAS_THREADS];
  tawas_ctx_t rd_data_q;

  // A read of the entry being written this cycle returns the new data.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) rd_data_q <= wr_data_i;
      else                                     rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tawas_regfile.sv
// Per-thread register-context file: loads a context in S3, merges S4/S5/S6 writes, stores it in S7.
module tawas_regfile
  import tawas_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         thread_load_en,
  input  logic [4:0]   thread_load,
  input  logic [4:0]   thread_decode,
  input  logic [4:0]   thread_store,
  input  logic         rf_imm_en,
  input  logic [2:0]   rf_imm_reg,
  input  logic [31:0]  rf_imm,
  input  logic         au_wr_en,
  input  logic [2:0]   au_wr_reg,
  input  logic [31:0]  au_wr_data,
  input  logic         ls_wr_en,
  input  logic [2:0]   ls_wr_reg,
  input  logic [31:0]  ls_wr_data,
  output logic [255:0] rf_rdata,
  output logic         rf_rdata_vld,
  output logic         rf_err
);

  logic         ctx4_vld_q;
  tawas_tid_t   ctx4_id_q;
  tawas_ctx_t   ctx4_ctx;
  tawas_stage_t ctx5_q, ctx5_d;
  tawas_stage_t ctx6_q, ctx6_d;
  tawas_stage_t ctx7_q, ctx7_d;
  logic         err_q, err_d;
  logic         mem_wr_en;
  logic         mem_rd_en;

  // Nothing in flight may reach storage on a reset edge.
  assign mem_wr_en = ctx7_q.valid && !rst;
  assign mem_rd_en = thread_load_en && !rst;

  tawas_rf_mem u_mem (
    .clk       (clk),
    .rd_en_i   (mem_rd_en),
    .rd_addr_i (thread_load),
    .rd_data_o (ctx4_ctx),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (ctx7_q.id),
    .wr_data_i (ctx7_q.ctx)
  );

  always_comb begin
    ctx5_d       = '0;
    ctx5_d.valid = ctx4_vld_q;
    ctx5_d.id    = ctx4_id_q;
    ctx5_d.ctx   = ctx_write(ctx4_ctx, ctx4_vld_q && rf_imm_en, rf_imm_reg, rf_imm);

    ctx6_d       = ctx5_q;
    ctx6_d.ctx   = ctx_write(ctx5_q.ctx, ctx5_q.valid && au_wr_en, au_wr_reg, au_wr_data);

    ctx7_d       = ctx6_q;
    ctx7_d.ctx   = ctx_write(ctx6_q.ctx, ctx6_q.valid && ls_wr_en, ls_wr_reg, ls_wr_data);

    err_d = err_q
          | (ctx4_vld_q   && (thread_decode != ctx4_id_q))
          | (ctx7_q.valid && (thread_store  != ctx7_q.id));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx4_vld_q <= 1'b0;
      ctx4_id_q  <= '0;
      ctx5_q     <= '0;
      ctx6_q     <= '0;
      ctx7_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ctx4_vld_q <= thread_load_en;
      ctx4_id_q  <= thread_load;
      ctx5_q     <= ctx5_d;
      ctx6_q     <= ctx6_d;
      ctx7_q     <= ctx7_d;
      err_q      <= err_d;
    end
  end

  // The storage read register is never reset, so the bus is forced to zero whenever S4 is empty.
  assign rf_rdata     = ctx4_vld_q ? ctx4_ctx : '0;
  assign rf_rdata_vld = ctx4_vld_q;
  assign rf_err       = err_q;

endmodule

// File: tb/tb_tawas_regfile.sv
// Self-checking bench for tawas_regfile: directed scenarios plus randomized traffic against a pass-level model.
module tb_tawas_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         thread_load_en = 1'b0;
  logic [4:0]   thread_load = '0;
  logic [4:0]   thread_decode = '0;
  logic [4:0]   thread_store = '0;
  logic         rf_imm_en = 1'b0;
  logic [2:0]   rf_imm_reg = '0;
  logic [31:0]  rf_imm = '0;
  logic         au_wr_en = 1'b0;
  logic [2:0]   au_wr_reg = '0;
  logic [31:0]  au_wr_data = '0;
  logic         ls_wr_en = 1'b0;
  logic [2:0]   ls_wr_reg = '0;
  logic [31:0]  ls_wr_data = '0;
  logic [255:0] rf_rdata;
  logic         rf_rdata_vld;
  logic         rf_err;

  int checks = 0;
  int failures = 0;

  tawas_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .thread_load_en (thread_load_en),
    .thread_load    (thread_load),
    .thread_decode  (thread_decode),
    .thread_store   (thread_store),
    .rf_imm_en      (rf_imm_en),
    .rf_imm_reg     (rf_imm_reg),
    .rf_imm         (rf_imm),
    .au_wr_en       (au_wr_en),
    .au_wr_reg      (au_wr_reg),
    .au_wr_data     (au_wr_data),
    .ls_wr_en       (ls_wr_en),
    .ls_wr_reg      (ls_wr_reg),
    .ls_wr_data     (ls_wr_data),
    .rf_rdata       (rf_rdata),
    .rf_rdata_vld   (rf_rdata_vld),
    .rf_err         (rf_err)
  );

  always #5 clk = ~clk;

  // One in-flight pass of a thread: its registers plus which of them hold software-written values.
  typedef struct packed {
    logic            v;
    logic [4:0]      id;
    logic [7:0][31:0] r;
    logic [7:0]      k;
  } pass_t;

  pass_t            fl [4];
  pass_t            nf [4];
  logic [7:0][31:0] mMem   [32];
  logic [7:0]       mKnown [32];
  logic             mErr = 1'b0;
  logic             errNow;
  bit               ready = 0;
  bit               justReset = 0;
  bit               overrideDecode = 0;

  initial begin
    for (int t = 0; t < 32; t++) begin
      mMem[t]   = '0;
      mKnown[t] = '0;
    end
    for (int s = 0; s < 4; s++) fl[s] = '0;
  end

  // Model: fl[s] is the pass that was loaded s+1 edges ago; the oldest commits to storage first.
  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) fl[s].v = 1'b0;
      mErr      = 1'b0;
      ready     = 1;
      justReset = 1;
    end else begin
      justReset = 0;
      errNow = (fl[0].v && (thread_decode != fl[0].id)) || (fl[3].v && (thread_store != fl[3].id));
      if (fl[3].v) begin
        mMem[fl[3].id]   = fl[3].r;
        mKnown[fl[3].id] = fl[3].k;
      end
      nf[3] = fl[2];
      if (fl[2].v && ls_wr_en) begin
        nf[3].r[ls_wr_reg] = ls_wr_data;
        nf[3].k[ls_wr_reg] = 1'b1;
      end
      nf[2] = fl[1];
      if (fl[1].v && au_wr_en) begin
        nf[2].r[au_wr_reg] = au_wr_data;
        nf[2].k[au_wr_reg] = 1'b1;
      end
      nf[1] = fl[0];
      if (fl[0].v && rf_imm_en) begin
        nf[1].r[rf_imm_reg] = rf_imm;
        nf[1].k[rf_imm_reg] = 1'b1;
      end
      nf[0]    = '0;
      nf[0].v  = thread_load_en;
      nf[0].id = thread_load;
      nf[0].r  = mMem[thread_load];
      nf[0].k  = mKnown[thread_load];
      for (int s = 0; s < 4; s++) fl[s] = nf[s];
      mErr = mErr | errNow;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every cycle: valid, sticky error, each known register of the S4 context, and a zero bus after reset.
  always @(negedge clk) begin
    if (ready) begin
      checkOutput("rdataVld", {31'b0, rf_rdata_vld}, {31'b0, fl[0].v});
      checkOutput("rfErr", {31'b0, rf_err}, {31'b0, mErr});
      if (fl[0].v) begin
        for (int r = 0; r < 8; r++)
          if (fl[0].k[r]) checkOutput($sformatf("rdata_t%0d_r%0d", fl[0].id, r), rf_rdata[r*32 +: 32], fl[0].r[r]);
      end
      if (justReset) begin
        checks++;
        if (rf_rdata !== 256'd0) begin
          failures++;
          $display("[TB] FAIL rdataAfterReset actual=%h required=0", rf_rdata);
        end
      end
    end
  end

  task automatic applyStimulus();
    if (!overrideDecode) thread_decode = fl[0].id;
    thread_store = fl[3].id;
    @(posedge clk);
    #1;
    thread_load_en = 1'b0;
    rf_imm_en      = 1'b0;
    au_wr_en       = 1'b0;
    ls_wr_en       = 1'b0;
  endtask

  task automatic loadThread(input logic [4:0] t);
    thread_load_en = 1'b1;
    thread_load    = t;
  endtask

  task automatic flush();
    repeat (5) applyStimulus();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Immediate to r3 of thread 5, visible on the next pass.
    loadThread(5); applyStimulus();
    rf_imm_en = 1'b1; rf_imm_reg = 3'd3; rf_imm = 32'h0000_1234; applyStimulus();
    repeat (3) applyStimulus();
    loadThread(5); applyStimulus();
    checkOutput("t5_r3_reload", rf_rdata[127:96], 32'h0000_1234);
    checkOutput("t5_vld", {31'b0, rf_rdata_vld}, 32'd1);
    flush();

    // Back-to-back threads 0,1,2 with distinct AU writes to r1.
    loadThread(0); applyStimulus();
    loadThread(1); applyStimulus();
    loadThread(2); au_wr_en = 1'b1; au_wr_reg = 3'd1; au_wr_data = 32'hA; applyStimulus();
    au_wr_en = 1'b1; au_wr_reg = 3'd1; au_wr_data = 32'hB; applyStimulus();
    au_wr_en = 1'b1; au_wr_reg = 3'd1; au_wr_data = 32'hC; applyStimulus();
    flush();
    loadThread(0); applyStimulus();
    checkOutput("t0_r1", rf_rdata[63:32], 32'hA);
    loadThread(1); applyStimulus();
    checkOutput("t1_r1", rf_rdata[63:32], 32'hB);
    loadThread(2); applyStimulus();
    checkOutput("t2_r1", rf_rdata[63:32], 32'hC);
    flush();

    // Thread 9: imm, AU and LS all hit r2 in one pass; the latest stage wins.
    loadThread(9); applyStimulus();
    rf_imm_en = 1'b1; rf_imm_reg = 3'd2; rf_imm = 32'd1; applyStimulus();
    au_wr_en = 1'b1; au_wr_reg = 3'd2; au_wr_data = 32'd2; applyStimulus();
    ls_wr_en = 1'b1; ls_wr_reg = 3'd2; ls_wr_data = 32'd3; applyStimulus();
    flush();
    loadThread(9); applyStimulus();
    checkOutput("t9_r2_latest", rf_rdata[95:64], 32'd3);
    flush();

    // Thread 7 stored and reloaded on the same edge.
    loadThread(7); applyStimulus();
    rf_imm_en = 1'b1; rf_imm_reg = 3'd0; rf_imm = 32'h77; applyStimulus();
    repeat (2) applyStimulus();
    loadThread(7); applyStimulus();
    checkOutput("t7_collision_r0", rf_rdata[31:0], 32'h77);
    flush();

    // Decode id mismatch sets the sticky error.
    loadThread(6); applyStimulus();
    overrideDecode = 1; thread_decode = 5'd4; applyStimulus();
    overrideDecode = 0;
    checkOutput("errRise", {31'b0, rf_err}, 32'd1);
    repeat (3) applyStimulus();
    checkOutput("errSticky", {31'b0, rf_err}, 32'd1);

    // Reset with four passes in flight: nothing stored, bus cleared, error cleared.
    loadThread(10); applyStimulus();
    rf_imm_en = 1'b1; rf_imm_reg = 3'd4; rf_imm = 32'h0000_AAAA; applyStimulus();
    flush();
    loadThread(10); applyStimulus();
    loadThread(11); rf_imm_en = 1'b1; rf_imm_reg = 3'd4; rf_imm = 32'h0000_DEAD; applyStimulus();
    loadThread(12); applyStimulus();
    loadThread(13); applyStimulus();
    rst = 1'b1; applyStimulus();
    checkOutput("rstVld", {31'b0, rf_rdata_vld}, 32'd0);
    checkOutput("rstRdataR4", rf_rdata[159:128], 32'd0);
    checkOutput("rstErr", {31'b0, rf_err}, 32'd0);
    rst = 1'b0;
    loadThread(10); applyStimulus();
    checkOutput("t10_keptAfterReset", rf_rdata[159:128], 32'h0000_AAAA);
    flush();

    // Randomized traffic, with enables often arriving at empty stages and a rare reset.
    for (int i = 0; i < 3000; i++) begin
      thread_load_en = ($urandom_range(0, 9) < 7);
      thread_load    = 5'($urandom_range(0, 31));
      rf_imm_en      = 1'($urandom);
      rf_imm_reg     = 3'($urandom);
      rf_imm         = $urandom;
      au_wr_en       = 1'($urandom);
      au_wr_reg      = 3'($urandom);
      au_wr_data     = $urandom;
      ls_wr_en       = 1'($urandom);
      ls_wr_reg      = 3'($urandom);
      ls_wr_data     = $urandom;
      rst            = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
